// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants: major opcodes, funct7 values and the
// aluop field layout consumed by EX.
package riscv_pkg;

  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef enum logic [2:0] {
    CLS_NOP   = 3'b000,
    CLS_REG   = 3'b001,
    CLS_IMM   = 3'b010,
    CLS_LUI   = 3'b011,
    CLS_AUIPC = 3'b100
  } alu_class_e;

  localparam int unsigned AOP_WORD    = 7;
  localparam int unsigned AOP_CLS_LSB = 4;
  localparam int unsigned AOP_ALT     = 3;
  localparam int unsigned AOP_F3_LSB  = 0;
  localparam int unsigned AOP_BITS    = 8;

  function automatic logic [AOP_BITS-1:0] pack_aluop(input logic       word,
                                                     input alu_class_e cls,
                                                     input logic       alt,
                                                     input logic [2:0] f3);
    logic [AOP_BITS-1:0] a;
    a                     = '0;
    a[AOP_WORD]           = word;
    a[AOP_CLS_LSB +: 3]   = cls;
    a[AOP_ALT]            = alt;
    a[AOP_F3_LSB +: 3]    = f3;
    return a;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// IF/ID input handshake and registered ID/EX bundle of the decode stage.
interface id_stage_if #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned ALUOP_W  = 8,
  parameter int unsigned ALUSEL_W = 3,
  parameter int unsigned RA_W     = 5
);
  logic                in_valid;
  logic                in_ready;
  logic [XLEN-1:0]     in_pc;
  logic [31:0]         in_inst;

  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     pc_o;
  logic [ALUOP_W-1:0]  aluop_o;
  logic [ALUSEL_W-1:0] alusel_o;
  logic [XLEN-1:0]     reg1_o;
  logic [XLEN-1:0]     reg2_o;
  logic [RA_W-1:0]     wa_o;
  logic                we_o;
  logic                illegal_o;

  // Surrounding pipeline: feeds instructions and accepts the bundle.
  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, pc_o, aluop_o, alusel_o,
           reg1_o, reg2_o, wa_o, we_o, illegal_o
  );

  // Decode stage itself.
  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, pc_o, aluop_o, alusel_o,
           reg1_o, reg2_o, wa_o, we_o, illegal_o
  );
endinterface

// File: rtl/id_imm_gen.sv
// Sign-extended I-type and U-type immediates for the decode stage.
module id_imm_gen #(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:12]     inst,
  output logic [XLEN-1:0]  imm_i,
  output logic [XLEN-1:0]  imm_u
);
  logic signed [11:0] i12;
  logic signed [31:0] u32;

  always_comb begin
    i12   = inst[31:20];
    u32   = {inst[31:12], 12'b0};
    imm_i = XLEN'(i12);
    imm_u = XLEN'(u32);
  end
endmodule

// File: rtl/id_stage.sv
// RISC-V integer ALU decode stage: operand fetch, legality check, load-use
// interlock and a registered ID/EX bundle under valid/ready.
module id_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned ALUOP_W  = 8,
  parameter int unsigned ALUSEL_W = 3,
  parameter int unsigned RA_W     = 5
) (
  input  logic            clk,
  input  logic            rst,
  id_stage_if.slave       bus,
  input  logic            flush,
  input  logic            ex_load_valid,
  input  logic [RA_W-1:0] ex_load_rd,
  output logic            rf_re1,
  output logic            rf_re2,
  output logic [RA_W-1:0] rf_addr1,
  output logic [RA_W-1:0] rf_addr2,
  input  logic [XLEN-1:0] rf_data1,
  input  logic [XLEN-1:0] rf_data2
);
  localparam bit IS64 = (XLEN == 64);

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [5:0]  f6;

  logic [XLEN-1:0] imm_i, imm_u;

  logic            legal, word, alt;
  alu_class_e      cls;
  logic [XLEN-1:0] op1, op2;
  logic [AOP_BITS-1:0] aluop_d;
  logic            we_d;
  logic            hz, accept;

  assign opcode = bus.in_inst[6:0];
  assign rd     = bus.in_inst[11:7];
  assign f3     = bus.in_inst[14:12];
  assign rs1    = bus.in_inst[19:15];
  assign rs2    = bus.in_inst[24:20];
  assign f7     = bus.in_inst[31:25];
  assign f6     = bus.in_inst[31:26];

  assign rf_addr1 = RA_W'(rs1);
  assign rf_addr2 = RA_W'(rs2);

  id_imm_gen #(.XLEN(XLEN)) u_imm (
    .inst  (bus.in_inst[31:12]),
    .imm_i (imm_i),
    .imm_u (imm_u)
  );

  always_comb begin
    rf_re1 = 1'b0;
    rf_re2 = 1'b0;
    legal  = 1'b0;
    word   = 1'b0;
    alt    = 1'b0;
    cls    = CLS_NOP;
    op1    = '0;
    op2    = '0;
    case (opcode)
      OP: begin
        rf_re1 = 1'b1;
        rf_re2 = 1'b1;
        cls    = CLS_REG;
        alt    = bus.in_inst[30];
        op1    = rf_data1;
        op2    = rf_data2;
        legal  = (f7 == F7_BASE) ||
                 ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
      end
      OP_IMM: begin
        rf_re1 = 1'b1;
        cls    = CLS_IMM;
        op1    = rf_data1;
        op2    = imm_i;
        // inst[25] is shamt[5] on RV64 but must be zero on RV32
        case (f3)
          F3_SLL: legal = (f6 == 6'b000000) && (IS64 || !bus.in_inst[25]);
          F3_SR: begin
            legal = ((f6 == 6'b000000) || (f6 == 6'b010000)) &&
                    (IS64 || !bus.in_inst[25]);
            alt   = bus.in_inst[30];
          end
          default: legal = 1'b1;
        endcase
      end
      OP_32: begin
        rf_re1 = 1'b1;
        rf_re2 = 1'b1;
        cls    = CLS_REG;
        word   = 1'b1;
        alt    = bus.in_inst[30];
        op1    = rf_data1;
        op2    = rf_data2;
        legal  = IS64 &&
                 (((f7 == F7_BASE) && ((f3 == F3_ADD) || (f3 == F3_SLL) || (f3 == F3_SR))) ||
                  ((f7 == F7_ALT)  && ((f3 == F3_ADD) || (f3 == F3_SR))));
      end
      OP_IMM_32: begin
        rf_re1 = 1'b1;
        cls    = CLS_IMM;
        word   = 1'b1;
        op1    = rf_data1;
        op2    = imm_i;
        case (f3)
          F3_ADD: legal = IS64;
          F3_SLL: legal = IS64 && (f7 == F7_BASE);
          F3_SR: begin
            legal = IS64 && ((f7 == F7_BASE) || (f7 == F7_ALT));
            alt   = bus.in_inst[30];
          end
          default: legal = 1'b0;
        endcase
      end
      LUI: begin
        cls   = CLS_LUI;
        legal = 1'b1;
        op2   = imm_u;
      end
      AUIPC: begin
        cls   = CLS_AUIPC;
        legal = 1'b1;
        op1   = bus.in_pc;
        op2   = imm_u;
      end
      default: legal = 1'b0;
    endcase

    aluop_d = legal ? pack_aluop(word, cls, alt, f3) : '0;
    we_d    = legal && (rd != 5'd0);
  end

  assign hz = bus.in_valid && ex_load_valid && (ex_load_rd != '0) &&
              ((rf_re1 && (rf_addr1 == ex_load_rd)) ||
               (rf_re2 && (rf_addr2 == ex_load_rd)));

  assign bus.in_ready = !rst && (!bus.out_valid || bus.out_ready) && !hz && !flush;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.pc_o      <= '0;
      bus.aluop_o   <= '0;
      bus.alusel_o  <= '0;
      bus.reg1_o    <= '0;
      bus.reg2_o    <= '0;
      bus.wa_o      <= '0;
      bus.we_o      <= 1'b0;
      bus.illegal_o <= 1'b0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.pc_o      <= bus.in_pc;
      bus.aluop_o   <= ALUOP_W'(aluop_d);
      bus.alusel_o  <= ALUSEL_W'(f3);
      bus.reg1_o    <= op1;
      bus.reg2_o    <= op2;
      bus.wa_o      <= RA_W'(rd);
      bus.we_o      <= we_d;
      bus.illegal_o <= !legal;
    end else if (bus.out_ready && bus.out_valid) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Parametrised, pipelined RISC-V decode stage between the IF/ID register and EX.
- Decodes the integer ALU subset (OP, OP-IMM, LUI, AUIPC, plus OP-32/OP-IMM-32 when XLEN=64) and generates sign-extended immediates.
- Reads operands from the register file and presents a registered ID/EX bundle under a valid/ready handshake.
- Adds a load-use interlock, a synchronous flush and an illegal-instruction flag.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- ALUOP_W, 8, width of aluop_o.
- ALUSEL_W, 3, width of alusel_o.
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  IF/ID holds an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_pc  in  XLEN  instruction PC.
- in_inst  in  32  instruction word.
- flush  in  1  kill the held output and the current input.
- ex_load_valid  in  1  EX holds a load.
- ex_load_rd  in  RA_W  destination of that load.
- rf_re1, rf_re2  out  1  register-file read enables (combinational).
- rf_addr1, rf_addr2  out  RA_W  register-file read addresses (combinational).
- rf_data1, rf_data2  in  XLEN  read data, same-cycle.
- out_valid  out  1  ID/EX bundle valid.
- out_ready  in  1  EX accepts the bundle.
- pc_o  out  XLEN  registered PC.
- aluop_o  out  ALUOP_W  operation code.
- alusel_o  out  ALUSEL_W  funct3.
- reg1_o, reg2_o  out  XLEN  operands.
- wa_o  out  RA_W  destination register.
- we_o  out  1  write enable.
- illegal_o  out  1  instruction not decodable.

Behaviour:
- Reset: all registered outputs are 0, including out_valid. in_ready=0 only while rst=1.
- Combinational decode from in_inst:
  - rf_addr1=rs1, rf_addr2=rs2.
  - re1 is set for OP, OP-IMM, OP-32 and OP-IMM-32; re2 is set for OP and OP-32 only.
- aluop bit fields:
  - [7]: word-op (32-bit variants).
  - [6:4]: class. 000 NOP, 001 REG, 010 IMM, 011 LUI, 100 AUIPC.
  - [3]: alt. inst[30] for OP, OP-32 and the shift-right immediates; otherwise 0.
  - [2:0]: funct3. alusel_o=funct3.
- Operands:
  - REG: reg1=rf_data1, reg2=rf_data2.
  - IMM: reg1=rf_data1, reg2=I-imm sign-extended to XLEN.
  - LUI: reg1=0, reg2={inst[31:12],12'b0} sign-extended.
  - AUIPC: reg1=in_pc, reg2=U-imm sign-extended.
- Legality; anything else sets illegal=1, class=NOP, we=0:
  - OP funct7 must be 0000000, or 0100000 only with funct3 000 or 101.
  - Shift immediates use shamt width log2(XLEN). The upper funct bits must be 0 or 0100000-equivalent, with the alt form legal only for funct3 101. For XLEN=32, inst[25] must be 0.
  - OP-32/OP-IMM-32 are illegal when XLEN=32. Their word shifts require inst[25]=0.
- we = legal && rd!=0. wa=rd.
- Hazard: hz = in_valid && ex_load_valid && ex_load_rd!=0 && ((re1 && rs1==ex_load_rd) || (re2 && rs2==ex_load_rd)).
- Handshake: in_ready = (!out_valid || out_ready) && !hz && !flush. Accept = in_valid && in_ready.
- Register update per cycle, in priority order:
  1. rst: clear all.
  2. flush: out_valid<=0, input dropped.
  3. accept: load the bundle, out_valid<=1.
  4. out_ready && out_valid without accept: out_valid<=0 (bubble; hz inserts a bubble this way).
  5. otherwise: hold all outputs stable.
- Latency: one cycle from accept to out_valid. One instruction per cycle throughput with no stalls.
- Illegal instructions pass downstream with illegal_o=1 for trap handling; they are never dropped.
- Bundle fields other than out_valid are don't-care while out_valid=0 but must not be X after reset.

Decomposition:
- Package riscv_pkg holds:
  - opcode constants: OP, OP_IMM, OP_32, OP_IMM_32, LUI, AUIPC.
  - aluop class encodings and the aluop field positions.
  - funct7 constants.
- One sub-module, id_imm_gen: a combinational inst and XLEN to I/U immediate generator.
- Hazard detection and the pipeline register stay in id_stage.

Test Plan:
1. XLEN=64, ADDI x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle out_valid=1, reg2_o=0xFFFFFFFFFFFFFFFF, aluop_o=0x20, we_o=1, wa_o=1.
2. LUI x2,0x80000 (0x80000137) -> reg2_o=0xFFFFFFFF80000000, reg1_o=0, aluop_o=0x30.
   - Same instruction with XLEN=32 -> reg2_o=0x80000000.
3. Backpressure: accept ADD x3,x1,x2 with out_ready=0 for 3 cycles -> in_ready=0 and the bundle is held unchanged. out_ready=1 -> next instruction accepted the same cycle.
4. Load-use: ex_load_valid=1, ex_load_rd=5, in_inst=ADD x6,x5,x0 -> in_ready=0, out_valid drops to 0 after the current bundle drains.
   - Deassert ex_load_valid -> accepted next cycle.
   - rd=0 load with a use of rs1=0 -> no stall.
5. Flush with in_valid=1 and out_valid=1 -> next cycle out_valid=0, input not captured.
   - rst=1 asserted mid-stream -> all outputs 0 next cycle.
6. Illegal: funct7=0100000 with funct3=001 on OP, and ADDW (0x0000003B) with XLEN=32 -> illegal_o=1, we_o=0, aluop class=NOP, out_valid=1.
